// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM-side request port between NUM_REQ
// requesters. The winning request is registered onto the mem port and the
// winner's index is kept in an in-order ID FIFO so that responses, which
// return in request order, can be steered back to their originator.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_we_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [DATA_W/8-1:0]         mem_strb_o,
  input  logic                        mem_rsp_valid_i,
  input  logic [DATA_W-1:0]           mem_rsp_data_i,
  input  logic                        mem_rsp_err_i,
  output logic [$clog2(MAX_OUT):0]    outstanding_o,
  output logic                        spurious_rsp_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W  = $clog2(MAX_OUT);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [IDX_W:0]   NUM_WRAP = (IDX_W+1)'(NUM_REQ);

  // round-robin pointer and arbitration results
  logic [IDX_W-1:0]  rr_r;
  logic [IDX_W-1:0]  win_s;
  logic              found_s;
  logic              free_s;
  logic              pop_s;
  logic              credit_s;
  logic              accept_s;

  // selected request fields of the winner
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_we_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [STRB_W-1:0] sel_strb_s;

  // in-order ID FIFO
  logic [IDX_W-1:0]  id_mem_r [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  head_s;

  // registered output stage
  logic              mem_valid_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [STRB_W-1:0] mem_strb_r;
  logic              spurious_r;

  // search requesters starting at rr_r for the first asserted valid
  always_comb begin : arb_search
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             hit;
    found_s = 1'b0;
    win_s   = rr_r;
    sum     = {(IDX_W+1){1'b0}};
    cand    = {IDX_W{1'b0}};
    hit     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum     = {1'b0, rr_r} + (IDX_W+1)'(i);
      cand    = (sum >= NUM_WRAP) ? IDX_W'(sum - NUM_WRAP) : IDX_W'(sum);
      hit     = !found_s && req_valid_i[cand];
      win_s   = hit ? cand : win_s;
      found_s = found_s | hit;
    end
  end

  // accept decision: stage free, credits available (a same-cycle pop frees one)
  always_comb begin
    free_s   = !mem_valid_r || mem_req_ready_i;
    pop_s    = mem_rsp_valid_i && (cnt_r != {CNT_W{1'b0}}) && !srst_i;
    credit_s = (cnt_r < MAX_CNT) || pop_s;
    accept_s = found_s && free_s && credit_s && !srst_i;
    head_s   = id_mem_r[rd_ptr_r];
  end

  // one-hot grant, one-hot response routing and the winner's field mux
  always_comb begin
    req_ready_o = {NUM_REQ{1'b0}};
    rsp_valid_o = {NUM_REQ{1'b0}};
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_we_s    = 1'b0;
    sel_wdata_s = {DATA_W{1'b0}};
    sel_strb_s  = {STRB_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = accept_s && (win_s == IDX_W'(i));
      rsp_valid_o[i] = pop_s && (head_s == IDX_W'(i));
      if (win_s == IDX_W'(i)) begin
        sel_addr_s  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_we_s    = req_we_i[i];
        sel_wdata_s = req_wdata_i[i*DATA_W +: DATA_W];
        sel_strb_s  = req_strb_i[i*STRB_W +: STRB_W];
      end else begin
        sel_addr_s  = sel_addr_s;
      end
    end
    rsp_data_o = mem_rsp_data_i;
    rsp_err_o  = pop_s & mem_rsp_err_i;
  end

  // advance the round-robin pointer past the winner on every accept
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rr_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      rr_r <= (win_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : win_s + IDX_W'(1);
    end else begin
      rr_r <= rr_r;
    end
  end

  // ID FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      id_mem_r[wr_ptr_r] <= win_s;
    end
  end

  // ID FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // output register: load on accept, drop after handshake, hold otherwise
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      mem_valid_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_strb_r  <= {STRB_W{1'b0}};
    end else if (accept_s) begin
      mem_valid_r <= 1'b1;
      mem_addr_r  <= sel_addr_s;
      mem_we_r    <= sel_we_s;
      mem_wdata_r <= sel_wdata_s;
      mem_strb_r  <= sel_strb_s;
    end else if (mem_req_ready_i) begin
      mem_valid_r <= 1'b0;
    end else begin
      mem_valid_r <= mem_valid_r;
    end
  end

  // sticky flag for responses that arrive with nothing outstanding
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      spurious_r <= 1'b0;
    end else if (mem_rsp_valid_i && (cnt_r == {CNT_W{1'b0}})) begin
      spurious_r <= 1'b1;
    end else begin
      spurious_r <= spurious_r;
    end
  end

  assign mem_req_valid_o = mem_valid_r;
  assign mem_addr_o      = mem_addr_r;
  assign mem_we_o        = mem_we_r;
  assign mem_wdata_o     = mem_wdata_r;
  assign mem_strb_o      = mem_strb_r;
  assign outstanding_o   = cnt_r;
  assign spurious_rsp_o  = spurious_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (4 requesters, 4 credits):
// a vector table, hand-written corner sequences and a randomized run, all
// compared against a queue-based reference model of the arbiter.
module tb_mem_port_arbiter;

  logic         clk;
  logic         srst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_addr;
  logic [3:0]   req_we;
  logic [255:0] req_wdata;
  logic [31:0]  req_strb;
  logic [3:0]   rsp_valid;
  logic [63:0]  rsp_data;
  logic         rsp_err;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_addr;
  logic         mem_we;
  logic [63:0]  mem_wdata;
  logic [7:0]   mem_strb;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_data;
  logic         mem_rsp_err;
  logic [2:0]   outstanding;
  logic         spurious;

  logic [31:0]  a_addr  [4];
  logic [63:0]  a_wdata [4];
  logic [7:0]   a_strb  [4];

  int checks = 0;
  int errors = 0;

  // reference model state
  int           mq[$];
  int           m_rr;
  bit           m_ov;
  logic [31:0]  m_addr;
  bit           m_we;
  logic [63:0]  m_wdata;
  logic [7:0]   m_strb;
  bit           m_spur;
  // reference model per-cycle results
  int           e_win;
  bit           e_acc;
  bit           e_pop;
  logic [3:0]   e_ready;
  logic [3:0]   e_rsp;

  typedef struct {
    logic [3:0] valid;
    logic       mr;
    logic       rv;
    logic       err;
    logic [3:0] e_ready;
    logic [3:0] e_rsp;
    logic [2:0] e_out;
    logic       e_mv;
    logic       e_spur;
  } vec_t;

  vec_t vt[16];

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .MAX_OUT(4)) dut (
    .clk_i(clk), .srst_i(srst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_strb_o(mem_strb), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_err_i(mem_rsp_err),
    .outstanding_o(outstanding), .spurious_rsp_o(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pack per-requester fields onto the flat request buses
  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = a_addr[i];
      req_wdata[i*64 +: 64] = a_wdata[i];
      req_strb[i*8 +: 8]    = a_strb[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_ov = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0; m_strb = '0; m_spur = 1'b0;
  endtask

  // what the arbiter should do this cycle, from the current inputs and model state
  task automatic model_comb();
    bit free, credit;
    e_pop  = mem_rsp_valid && (mq.size() > 0) && !srst;
    free   = !m_ov || mem_req_ready;
    credit = (mq.size() < 4) || e_pop;
    e_win  = -1;
    for (int k = 0; k < 4; k++) begin
      int r;
      r = (m_rr + k) % 4;
      if (e_win < 0 && req_valid[r]) e_win = r;
    end
    e_acc   = !srst && (e_win >= 0) && free && credit;
    e_ready = e_acc ? (4'b0001 << e_win) : 4'b0000;
    e_rsp   = e_pop ? (4'b0001 << mq[0]) : 4'b0000;
  endtask

  task automatic model_update();
    if (srst) begin
      model_reset();
    end else begin
      if (mem_rsp_valid && mq.size() == 0) m_spur = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (e_acc) begin
        mq.push_back(e_win);
        m_rr = (e_win + 1) % 4;
        m_ov = 1'b1;
        m_addr = a_addr[e_win]; m_we = req_we[e_win];
        m_wdata = a_wdata[e_win]; m_strb = a_strb[e_win];
      end else if (mem_req_ready) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // sample on the falling edge and compare every output to the model
  task automatic sample();
    @(negedge clk);
    model_comb();
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    if (e_pop) begin
      chk("rsp_data", rsp_data, mem_rsp_data);
      chk("rsp_err", 64'(rsp_err), 64'(mem_rsp_err));
    end
    chk("mem_req_valid", 64'(mem_req_valid), 64'(m_ov));
    if (m_ov) begin
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_strb", 64'(mem_strb), 64'(m_strb));
    end
    chk("outstanding", 64'(outstanding), 64'(mq.size()));
    chk("spurious", 64'(spurious), 64'(m_spur));
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 4'b0000; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = 64'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    srst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    srst = 1'b0;
    model_reset();
  endtask

  initial begin
    int gcount[4];
    int acc;
    int exp_seq[3];
    logic [3:0] pend;

    vt[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd0, 1'b0, 1'b0};
    vt[2]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 3'd1, 1'b1, 1'b0};
    vt[3]  = '{4'b1100, 1'b1, 1'b0, 1'b0, 4'b0100, 4'b0000, 3'd2, 1'b1, 1'b0};
    vt[4]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000, 3'd3, 1'b1, 1'b0};
    vt[5]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[6]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0001, 3'd4, 1'b0, 1'b0};
    vt[7]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0010, 3'd4, 1'b1, 1'b0};
    vt[8]  = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0100, 3'd3, 1'b0, 1'b0};
    vt[9]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd3, 1'b1, 1'b0};
    vt[10] = '{4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b1000, 3'd3, 1'b1, 1'b0};
    vt[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd3, 1'b1, 1'b0};
    vt[12] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 3'd2, 1'b0, 1'b0};
    vt[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0, 1'b0};
    vt[14] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0};
    vt[15] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b1};

    srst = 1'b1;
    req_we = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      a_addr[i]  = 32'(256 * (i + 1));
      a_wdata[i] = {32'hC0DE_0000, 32'(i)};
      a_strb[i]  = 8'(1 << i);
    end
    do_reset();

    // reset values
    chk("rst_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_mem_strb", 64'(mem_strb), 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_spurious", 64'(spurious), 64'h0);

    // vector table
    for (int r = 0; r < 16; r++) begin
      req_valid = vt[r].valid; mem_req_ready = vt[r].mr;
      mem_rsp_valid = vt[r].rv; mem_rsp_err = vt[r].err;
      mem_rsp_data = 64'hA5A5_0000_0000_0000 | 64'(r);
      sample();
      chk("tbl_ready", 64'(req_ready), 64'(vt[r].e_ready));
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(vt[r].e_rsp));
      chk("tbl_outstanding", 64'(outstanding), 64'(vt[r].e_out));
      chk("tbl_mem_valid", 64'(mem_req_valid), 64'(vt[r].e_mv));
      chk("tbl_spurious", 64'(spurious), 64'(vt[r].e_spur));
      if (vt[r].e_rsp != 4'b0000) chk("tbl_rsp_err", 64'(rsp_err), 64'(vt[r].err));
      advance();
    end

    // single request from requester 2, response 3 cycles after handshake
    do_reset();
    a_addr[2] = 32'h1000_0000; req_we = 4'b0000;
    req_valid = 4'b0100;
    sample(); chk("single_grant", 64'(req_ready), 64'h4); advance();
    req_valid = 4'b0000;
    sample();
    chk("single_mvalid", 64'(mem_req_valid), 64'h1);
    chk("single_addr", 64'(mem_addr), 64'h1000_0000);
    chk("single_we", 64'(mem_we), 64'h0);
    chk("single_out1", 64'(outstanding), 64'h1);
    advance();
    sample(); chk("single_mdrop", 64'(mem_req_valid), 64'h0); advance();
    sample(); advance();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234_5678_90AB_CDEF;
    sample();
    chk("single_rsp", 64'(rsp_valid), 64'h4);
    chk("single_data", rsp_data, 64'h1234_5678_90AB_CDEF);
    advance();
    mem_rsp_valid = 1'b0;
    sample(); chk("single_out0", 64'(outstanding), 64'h0); advance();

    // fairness with immediate responses
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) gcount[i] = 0;
    for (int k = 0; k < 16; k++) begin
      mem_rsp_valid = (k > 0);
      sample();
      chk("fair_order", 64'(req_ready), 64'(1) << (k % 4));
      if (k > 0) chk("fair_route", 64'(rsp_valid), 64'(1) << ((k - 1) % 4));
      for (int i = 0; i < 4; i++) if (req_ready[i]) gcount[i]++;
      advance();
    end
    for (int i = 0; i < 4; i++) chk("fair_count", 64'(gcount[i]), 64'd4);

    // credit limit
    do_reset();
    req_valid = 4'b1111;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (k < 4) chk("credit_grant", 64'(req_ready), 64'(1) << k);
      else       chk("credit_block", 64'(req_ready), 64'h0);
      if (req_ready != 4'b0000) acc++;
      advance();
    end
    chk("credit_accepts", 64'(acc), 64'd4);
    mem_rsp_valid = 1'b1;
    sample();
    chk("credit_pop_grant", 64'(req_ready), 64'h1);
    chk("credit_pop_rsp", 64'(rsp_valid), 64'h1);
    advance();
    mem_rsp_valid = 1'b0;
    sample();
    chk("credit_full_again", 64'(req_ready), 64'h0);
    chk("credit_out", 64'(outstanding), 64'd4);
    advance();

    // backpressure on a held write
    do_reset();
    a_addr[1] = 32'h2000_0040; req_we = 4'b0010;
    a_wdata[1] = 64'h0000_0000_DEAD_BEEF; a_strb[1] = 8'h0F;
    mem_req_ready = 1'b0; req_valid = 4'b0010;
    sample(); chk("bp_grant", 64'(req_ready), 64'h2); advance();
    req_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("bp_no_accept", 64'(req_ready), 64'h0);
      chk("bp_valid", 64'(mem_req_valid), 64'h1);
      chk("bp_addr", 64'(mem_addr), 64'h2000_0040);
      chk("bp_we", 64'(mem_we), 64'h1);
      chk("bp_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
      chk("bp_strb", 64'(mem_strb), 64'h0F);
      advance();
    end
    mem_req_ready = 1'b1;
    sample(); chk("bp_rr_kept", 64'(req_ready), 64'h8); advance();
    req_valid = 4'b0001;
    sample(); chk("bp_next", 64'(req_ready), 64'h1); advance();
    req_valid = 4'b0000;
    sample(); advance();

    // reset mid-operation, then a spurious response
    do_reset();
    req_valid = 4'b0011;
    sample(); chk("rs_g0", 64'(req_ready), 64'h1); advance();
    req_valid = 4'b0010;
    sample(); chk("rs_g1", 64'(req_ready), 64'h2); advance();
    req_valid = 4'b0000;
    sample(); chk("rs_out2", 64'(outstanding), 64'h2); advance();
    srst = 1'b1; req_valid = 4'b0100; mem_rsp_valid = 1'b1;
    sample();
    chk("rs_ready_in_rst", 64'(req_ready), 64'h0);
    chk("rs_rsp_in_rst", 64'(rsp_valid), 64'h0);
    advance();
    srst = 1'b0; req_valid = 4'b0000; mem_rsp_valid = 1'b1;
    sample();
    chk("rs_dropped", 64'(rsp_valid), 64'h0);
    chk("rs_out0", 64'(outstanding), 64'h0);
    advance();
    mem_rsp_valid = 1'b0;
    sample();
    chk("rs_spurious", 64'(spurious), 64'h1);
    chk("rs_out_after", 64'(outstanding), 64'h0);
    advance();

    // routing order 3, 0, 1 with an error on the second response
    do_reset();
    req_valid = 4'b1000; sample(); chk("ro_g3", 64'(req_ready), 64'h8); advance();
    req_valid = 4'b0001; sample(); chk("ro_g0", 64'(req_ready), 64'h1); advance();
    req_valid = 4'b0010; sample(); chk("ro_g1", 64'(req_ready), 64'h2); advance();
    req_valid = 4'b0000;
    exp_seq[0] = 8; exp_seq[1] = 1; exp_seq[2] = 2;
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = 1'b1; mem_rsp_err = (k == 1);
      mem_rsp_data = 64'(k + 100);
      sample();
      chk("ro_route", 64'(rsp_valid), 64'(exp_seq[k]));
      chk("ro_err", 64'(rsp_err), (k == 1) ? 64'h1 : 64'h0);
      advance();
    end
    idle_inputs();

    // randomized traffic against the model
    do_reset();
    pend = 4'b0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          a_addr[i] = $urandom; req_we[i] = $urandom_range(0, 1) == 1;
          a_wdata[i] = {$urandom, $urandom}; a_strb[i] = 8'($urandom);
        end
      end
      req_valid     = pend;
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_data  = {$urandom, $urandom};
      mem_rsp_err   = ($urandom_range(0, 7) == 0);
      srst          = ($urandom_range(0, 299) == 0);
      sample();
      if (e_acc) pend[e_win] = 1'b0;
      advance();
    end
    srst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
